btn_press_conditioner: RTL and testbench

// Input-side front end for the buzzer tone generators: converts a raw, bouncing push-button into clean

---
 rtl/btn_press_conditioner.sv | 154 +++++++++++++++
 tb/tb_btn_press_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/btn_press_conditioner.sv
// Push-button front end: synchronizes and debounces a raw button pin, classifies
// short/long presses and produces a retriggerable beep enable for the tone block.
//
// state      | meaning
// IDLE       | button released, waiting for a pressed sample
// DB_PRESS   | pressed level seen, waiting for it to stay stable
// PRESSED    | press accepted, hold timer running
// LONG_HELD  | long press already reported, waiting for release
// DB_RELEASE | released level seen, waiting for it to stay stable
module btn_press_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 150_000_000,
  parameter int BEEP_CYCLES       = 5_000_000,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic beep_en
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  // The beep timer has to hold the load value itself, hence the +1.
  localparam int BEEP_W = (BEEP_CYCLES > 0) ? $clog2(BEEP_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);
  localparam logic              RELEASED  = BTN_ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    LONG_HELD  = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic              sync1, sync2, p;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [BEEP_W-1:0] beep_cnt;
  logic              from_long;
  logic              db_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ RELEASED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      btn_level <= (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                   (state_nxt == DB_RELEASE);
    end
  end

  always_comb begin
    state_nxt     = state;
    press_pulse   = 1'b0;
    release_pulse = 1'b0;
    long_pulse    = 1'b0;
    db_run        = 1'b0;
    case (state)
      IDLE: begin
        if (p) state_nxt = DB_PRESS;
      end
      DB_PRESS: begin
        if (!p) begin
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = PRESSED;
          press_pulse = 1'b1;
        end else begin
          db_run = 1'b1;
        end
      end
      PRESSED: begin
        // Long press wins over a release sample in the same cycle so the
        // long report is never lost once the hold time has elapsed.
        if (hold_cnt == HOLD_LAST) begin
          state_nxt  = LONG_HELD;
          long_pulse = 1'b1;
        end else if (!p) begin
          state_nxt = DB_RELEASE;
        end
      end
      LONG_HELD: begin
        if (!p) state_nxt = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (p) begin
          state_nxt = from_long ? LONG_HELD : PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt     = IDLE;
          release_pulse = 1'b1;
        end else begin
          db_run = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // db_run is only raised below the terminal count, so this never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         db_cnt <= '0;
    else if (db_run) db_cnt <= db_cnt + DB_W'(1);
    else             db_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (press_pulse || state == IDLE) begin
      hold_cnt <= '0;
    end else if (state != DB_PRESS && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Remembers where a release glitch should return to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      from_long <= 1'b0;
    else if (state != DB_RELEASE) from_long <= (state == LONG_HELD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   beep_cnt <= '0;
    else if (press_pulse)      beep_cnt <= BEEP_LOAD;
    else if (beep_cnt != '0)   beep_cnt <= beep_cnt - BEEP_W'(1);
  end

  assign beep_en = (beep_cnt != '0);

endmodule

// File: tb/tb_btn_press_conditioner.sv
// Directed bench for btn_press_conditioner: an active-low instance with the nominal
// small parameters and an active-high instance with a longer beep for retrigger.
module tb_btn_press_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw, btn_raw_ah;
  logic btn_level, press_pulse, release_pulse, long_pulse, beep_en;
  logic level_ah, press_ah, release_ah, long_ah, beep_ah;

  int tests_run = 0;
  int tests_failed = 0;

  int  cyc, n_press, press1, press2, n_release, rel1, n_long, long1;
  int  n_beep, beep_first, beep_last, n_level, level_first, level_last, n_multi;
  bit  sel_ah = 1'b0;

  btn_press_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .BEEP_CYCLES(8), .BTN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .beep_en(beep_en)
  );

  btn_press_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .BEEP_CYCLES(16), .BTN_ACTIVE_LOW(1'b0)
  ) u_dut_ah (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_ah), .btn_level(level_ah),
    .press_pulse(press_ah), .release_pulse(release_ah),
    .long_pulse(long_ah), .beep_en(beep_ah)
  );

  always #5 clk = ~clk;

  task automatic clear_obs();
    cyc = 0; n_press = 0; press1 = 0; press2 = 0; n_release = 0; rel1 = 0;
    n_long = 0; long1 = 0; n_beep = 0; beep_first = 0; beep_last = 0;
    n_level = 0; level_first = 0; level_last = 0; n_multi = 0;
  endtask

  task automatic step();
    logic o_press, o_rel, o_long, o_beep, o_level;
    @(posedge clk);
    #1;
    cyc++;
    o_press = sel_ah ? press_ah   : press_pulse;
    o_rel   = sel_ah ? release_ah : release_pulse;
    o_long  = sel_ah ? long_ah    : long_pulse;
    o_beep  = sel_ah ? beep_ah    : beep_en;
    o_level = sel_ah ? level_ah   : btn_level;
    if (o_press === 1'b1) begin
      n_press++;
      if (n_press == 1) press1 = cyc; else press2 = cyc;
    end
    if (o_rel === 1'b1) begin
      n_release++;
      if (n_release == 1) rel1 = cyc;
    end
    if (o_long === 1'b1) begin
      n_long++;
      if (n_long == 1) long1 = cyc;
    end
    if (o_beep === 1'b1) begin
      n_beep++;
      if (beep_first == 0) beep_first = cyc;
      beep_last = cyc;
    end
    if (o_level === 1'b1) begin
      n_level++;
      if (level_first == 0) level_first = cyc;
      level_last = cyc;
    end
    if ((int'(o_press === 1'b1) + int'(o_rel === 1'b1) + int'(o_long === 1'b1)) > 1) n_multi++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_raw = 1'b1; btn_raw_ah = 1'b0;
    #1 rst = 1'b1;
    #2;
    tests_run++; if ({btn_level, press_pulse, release_pulse, long_pulse, beep_en} !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs got %b want 00000", {btn_level, press_pulse, release_pulse, long_pulse, beep_en}); end
    tests_run++; if ({level_ah, press_ah, release_ah, long_ah, beep_ah} !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs_ah got %b want 00000", {level_ah, press_ah, release_ah, long_ah, beep_ah}); end
    @(posedge clk); #1 rst = 1'b0;
    clear_obs(); steps(6);
    tests_run++; if (n_press + n_release + n_long + n_beep + n_level !== 0) begin tests_failed++; $display("FAIL reset_idle_activity got %0d want 0", n_press + n_release + n_long + n_beep + n_level); end
  endtask

  task automatic test_clean_press();
    clear_obs();
    btn_raw = 1'b0; steps(30);
    btn_raw = 1'b1; steps(12);
    tests_run++; if (n_press !== 1)     begin tests_failed++; $display("FAIL clean press_count got %0d want 1", n_press); end
    tests_run++; if (press1 !== 6)      begin tests_failed++; $display("FAIL clean press_cycle got %0d want 6", press1); end
    tests_run++; if (n_beep !== 8)      begin tests_failed++; $display("FAIL clean beep_cycles got %0d want 8", n_beep); end
    tests_run++; if (beep_first !== 7)  begin tests_failed++; $display("FAIL clean beep_start got %0d want 7", beep_first); end
    tests_run++; if (beep_last !== 14)  begin tests_failed++; $display("FAIL clean beep_end got %0d want 14", beep_last); end
    tests_run++; if (n_long !== 1)      begin tests_failed++; $display("FAIL clean long_count got %0d want 1", n_long); end
    tests_run++; if (long1 !== 26)      begin tests_failed++; $display("FAIL clean long_cycle got %0d want 26", long1); end
    tests_run++; if (n_release !== 1)   begin tests_failed++; $display("FAIL clean release_count got %0d want 1", n_release); end
    tests_run++; if (rel1 !== 36)       begin tests_failed++; $display("FAIL clean release_cycle got %0d want 36", rel1); end
    tests_run++; if (level_first !== 7) begin tests_failed++; $display("FAIL clean level_rise got %0d want 7", level_first); end
    tests_run++; if (n_level !== 30 || level_last !== 36) begin tests_failed++; $display("FAIL clean level_span got %0d cycles ending %0d want 30 ending 36", n_level, level_last); end
    tests_run++; if (n_multi !== 0)     begin tests_failed++; $display("FAIL clean pulse_overlap got %0d want 0", n_multi); end
  endtask

  task automatic test_bounce();
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      btn_raw = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
      step();
    end
    btn_raw = 1'b1; steps(10);
    tests_run++; if (n_press + n_release + n_long !== 0) begin tests_failed++; $display("FAIL bounce pulses got %0d want 0", n_press + n_release + n_long); end
    tests_run++; if (n_level !== 0) begin tests_failed++; $display("FAIL bounce level_cycles got %0d want 0", n_level); end
    tests_run++; if (n_beep !== 0)  begin tests_failed++; $display("FAIL bounce beep_cycles got %0d want 0", n_beep); end
  endtask

  task automatic test_release_glitch();
    clear_obs();
    btn_raw = 1'b0; steps(10);
    btn_raw = 1'b1; steps(2);
    btn_raw = 1'b0; steps(18);
    btn_raw = 1'b1; steps(12);
    tests_run++; if (n_press !== 1)    begin tests_failed++; $display("FAIL glitch press_count got %0d want 1", n_press); end
    tests_run++; if (n_release !== 1 || rel1 !== 36) begin tests_failed++; $display("FAIL glitch release got %0d at %0d want 1 at 36", n_release, rel1); end
    tests_run++; if (n_long !== 1 || long1 !== 26)   begin tests_failed++; $display("FAIL glitch long got %0d at %0d want 1 at 26", n_long, long1); end
    tests_run++; if (n_level !== 30 || level_last !== 36) begin tests_failed++; $display("FAIL glitch level_span got %0d cycles ending %0d want 30 ending 36", n_level, level_last); end
  endtask

  task automatic test_short_press();
    clear_obs();
    btn_raw = 1'b0; steps(10);
    btn_raw = 1'b1; steps(12);
    tests_run++; if (press1 !== 6 || n_press !== 1)  begin tests_failed++; $display("FAIL short press got %0d at %0d want 1 at 6", n_press, press1); end
    tests_run++; if (rel1 !== 16 || n_release !== 1) begin tests_failed++; $display("FAIL short release got %0d at %0d want 1 at 16", n_release, rel1); end
    tests_run++; if (n_long !== 0) begin tests_failed++; $display("FAIL short long_count got %0d want 0", n_long); end
    tests_run++; if (n_beep !== 8) begin tests_failed++; $display("FAIL short beep_cycles got %0d want 8", n_beep); end
  endtask

  task automatic test_back_to_back();
    sel_ah = 1'b1;
    clear_obs();
    btn_raw_ah = 1'b1; steps(6);
    btn_raw_ah = 1'b0; steps(6);
    btn_raw_ah = 1'b1; steps(10);
    btn_raw_ah = 1'b0; steps(23);
    tests_run++; if (n_press !== 2 || press1 !== 6 || press2 !== 18) begin tests_failed++; $display("FAIL retrig presses got %0d at %0d,%0d want 2 at 6,18", n_press, press1, press2); end
    tests_run++; if (n_beep !== 28)    begin tests_failed++; $display("FAIL retrig beep_cycles got %0d want 28", n_beep); end
    tests_run++; if (beep_first !== 7 || beep_last !== 34) begin tests_failed++; $display("FAIL retrig beep_window got %0d..%0d want 7..34", beep_first, beep_last); end
    tests_run++; if (n_release !== 2 || rel1 !== 12) begin tests_failed++; $display("FAIL retrig releases got %0d first %0d want 2 first 12", n_release, rel1); end
    tests_run++; if (n_long !== 0)     begin tests_failed++; $display("FAIL retrig long_count got %0d want 0", n_long); end
    sel_ah = 1'b0;
  endtask

  task automatic test_polarity();
    sel_ah = 1'b1;
    clear_obs();
    btn_raw_ah = 1'b1; steps(10);
    btn_raw_ah = 1'b0; steps(16);
    tests_run++; if (n_press !== 1 || press1 !== 6)  begin tests_failed++; $display("FAIL polarity press got %0d at %0d want 1 at 6", n_press, press1); end
    tests_run++; if (n_release !== 1 || rel1 !== 16) begin tests_failed++; $display("FAIL polarity release got %0d at %0d want 1 at 16", n_release, rel1); end
    tests_run++; if (level_first !== 7 || level_last !== 16) begin tests_failed++; $display("FAIL polarity level_window got %0d..%0d want 7..16", level_first, level_last); end
    tests_run++; if (n_beep !== 16)  begin tests_failed++; $display("FAIL polarity beep_cycles got %0d want 16", n_beep); end
    sel_ah = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    clear_obs();
    btn_raw = 1'b0; steps(30);
    tests_run++; if (btn_level !== 1'b1 || n_long !== 1) begin tests_failed++; $display("FAIL midrst held_state got level %b longs %0d want 1 and 1", btn_level, n_long); end
    rst = 1'b1;
    #1;
    tests_run++; if ({btn_level, press_pulse, release_pulse, long_pulse, beep_en} !== 5'b0) begin tests_failed++; $display("FAIL midrst outputs got %b want 00000", {btn_level, press_pulse, release_pulse, long_pulse, beep_en}); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    clear_obs(); steps(30);
    tests_run++; if (n_press !== 1 || press1 !== 6) begin tests_failed++; $display("FAIL midrst press got %0d at %0d want 1 at 6", n_press, press1); end
    tests_run++; if (n_long !== 1 || long1 !== 26)  begin tests_failed++; $display("FAIL midrst long got %0d at %0d want 1 at 26", n_long, long1); end
    btn_raw = 1'b1; steps(12);
    tests_run++; if (n_release !== 1 || rel1 !== 36) begin tests_failed++; $display("FAIL midrst release got %0d at %0d want 1 at 36", n_release, rel1); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_short_press();
    test_back_to_back();
    test_polarity();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
